// File: rtl/pbkdf2_host_if.sv
`default_nettype none
// ============================================================================
// Module      : pbkdf2_host_if
// Description : Word-serial host front end for one pbkdf2 core. Assembles a
//               34-word job from a 32-bit command stream, holds the operands
//               stable for the core, issues the job, captures the 256-bit key
//               and returns it as 8 result words (MS word first).
//               Optional macro PBKDF2_HOST_CYCLE_COUNT_EN appends a 9th
//               result word: the saturating ISSUE+WAIT cycle count.
// Revision    : 1.0 - initial release
// ============================================================================
module pbkdf2_host_if (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [31:0]  cmd_data_i,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    output logic [31:0]  res_data_o,
    output logic         res_valid_o,
    input  logic         res_ready_i,
    output logic [31:0]  core_iters_o,
    output logic [511:0] core_pass_o,
    output logic [511:0] core_salt_o,
    output logic [5:0]   core_salt_len_o,
    output logic         core_in_valid_o,
    input  logic         core_in_ready_i,
    input  logic [255:0] core_hash_i,
    input  logic         core_out_valid_i,
    output logic         core_out_ready_o,
    output logic         busy_o
);

`ifdef PBKDF2_HOST_CYCLE_COUNT_EN
    localparam int IDX_W   = 4;
    localparam int NUM_RES = 9;
`else
    localparam int IDX_W   = 3;
    localparam int NUM_RES = 8;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_RES - 1);
    localparam logic [5:0]       LAST_WORD = 6'd33;
    localparam logic [5:0]       PASS_END  = 6'd17;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_SEND  = 2'd3
    } state_t;

    state_t             state_q;
    logic [5:0]         word_cnt_q;
    logic [IDX_W-1:0]   res_idx_q;
    logic [31:0]        iters_q;
    logic [5:0]         salt_len_q;
    logic [511:0]       pass_q;
    logic [511:0]       salt_q;
    logic [255:0]       result_q;
    logic               cmd_ready_q;
    logic               in_valid_q;
    logic               out_ready_q;
    logic               res_valid_q;
`ifdef PBKDF2_HOST_CYCLE_COUNT_EN
    logic [31:0]        cyc_q;
`endif

    logic [7:0]         w_base;
    logic [31:0]        w_word;

    // Job sequencer: operand capture, core handshakes and result streaming.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_LOAD;
            word_cnt_q  <= '0;
            res_idx_q   <= '0;
            iters_q     <= '0;
            salt_len_q  <= '0;
            pass_q      <= '0;
            salt_q      <= '0;
            result_q    <= '0;
            cmd_ready_q <= 1'b1;
            in_valid_q  <= 1'b0;
            out_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
`ifdef PBKDF2_HOST_CYCLE_COUNT_EN
            cyc_q       <= '0;
`endif
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (cmd_valid_i) begin
                        // Pass and salt arrive MS word first, so shifting
                        // left lands the first word at the top after 16.
                        if (word_cnt_q == 6'd0) begin
                            // The core never terminates on 0 iterations.
                            iters_q <= (cmd_data_i == 32'd0) ? 32'd1 : cmd_data_i;
                        end else if (word_cnt_q == 6'd1) begin
                            salt_len_q <= cmd_data_i[5:0];
                        end else if (word_cnt_q <= PASS_END) begin
                            pass_q <= {pass_q[479:0], cmd_data_i};
                        end else begin
                            salt_q <= {salt_q[479:0], cmd_data_i};
                        end
                        if (word_cnt_q == LAST_WORD) begin
                            word_cnt_q  <= '0;
                            state_q     <= S_ISSUE;
                            cmd_ready_q <= 1'b0;
                            in_valid_q  <= 1'b1;
`ifdef PBKDF2_HOST_CYCLE_COUNT_EN
                            cyc_q       <= '0;
`endif
                        end else begin
                            word_cnt_q <= word_cnt_q + 6'd1;
                        end
                    end
                end
                S_ISSUE: begin
`ifdef PBKDF2_HOST_CYCLE_COUNT_EN
                    if (cyc_q != 32'hFFFF_FFFF) cyc_q <= cyc_q + 32'd1;
`endif
                    if (core_in_ready_i) begin
                        state_q     <= S_WAIT;
                        in_valid_q  <= 1'b0;
                        out_ready_q <= 1'b1;
                    end
                end
                S_WAIT: begin
`ifdef PBKDF2_HOST_CYCLE_COUNT_EN
                    if (cyc_q != 32'hFFFF_FFFF) cyc_q <= cyc_q + 32'd1;
`endif
                    if (core_out_valid_i) begin
                        result_q    <= core_hash_i;
                        state_q     <= S_SEND;
                        out_ready_q <= 1'b0;
                        res_valid_q <= 1'b1;
                        res_idx_q   <= '0;
                    end
                end
                S_SEND: begin
                    if (res_ready_i) begin
                        if (res_idx_q == LAST_IDX) begin
                            res_idx_q   <= '0;
                            state_q     <= S_LOAD;
                            res_valid_q <= 1'b0;
                            cmd_ready_q <= 1'b1;
                        end else begin
                            res_idx_q <= res_idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

    // Result word select: MS word of the key first, optional count last.
    always_comb begin
        w_base = 8'd255 - {res_idx_q[2:0], 5'b0_0000};
        w_word = result_q[w_base -: 32];
`ifdef PBKDF2_HOST_CYCLE_COUNT_EN
        if (res_idx_q == LAST_IDX) w_word = cyc_q;
`endif
    end

    assign res_data_o       = res_valid_q ? w_word : 32'd0;
    assign res_valid_o      = res_valid_q;
    assign cmd_ready_o      = cmd_ready_q;
    assign core_in_valid_o  = in_valid_q;
    assign core_out_ready_o = out_ready_q;
    assign core_iters_o     = iters_q;
    assign core_pass_o      = pass_q;
    assign core_salt_o      = salt_q;
    assign core_salt_len_o  = salt_len_q;
    assign busy_o           = !((state_q == S_LOAD) && (word_cnt_q == 6'd0));

endmodule
`default_nettype wire

// File: tb/tb_pbkdf2_host_if.sv
`default_nettype none
// ============================================================================
// Module      : tb_pbkdf2_host_if
// Description : Directed self-checking bench for pbkdf2_host_if with a
//               result-word scoreboard fed by the core model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pbkdf2_host_if;

`ifdef PBKDF2_HOST_CYCLE_COUNT_EN
    localparam int NUM_RES = 9;
`else
    localparam int NUM_RES = 8;
`endif

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic [31:0]  cmd_data_i;
    logic         cmd_valid_i;
    logic         cmd_ready_o;
    logic [31:0]  res_data_o;
    logic         res_valid_o;
    logic         res_ready_i;
    logic [31:0]  core_iters_o;
    logic [511:0] core_pass_o;
    logic [511:0] core_salt_o;
    logic [5:0]   core_salt_len_o;
    logic         core_in_valid_o;
    logic         core_in_ready_i;
    logic [255:0] core_hash_i;
    logic         core_out_valid_i;
    logic         core_out_ready_o;
    logic         busy_o;

    int           checks = 0;
    int           errors = 0;
    logic [31:0]  exp_q[$];

    pbkdf2_host_if dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .cmd_data_i       (cmd_data_i),
        .cmd_valid_i      (cmd_valid_i),
        .cmd_ready_o      (cmd_ready_o),
        .res_data_o       (res_data_o),
        .res_valid_o      (res_valid_o),
        .res_ready_i      (res_ready_i),
        .core_iters_o     (core_iters_o),
        .core_pass_o      (core_pass_o),
        .core_salt_o      (core_salt_o),
        .core_salt_len_o  (core_salt_len_o),
        .core_in_valid_o  (core_in_valid_o),
        .core_in_ready_i  (core_in_ready_i),
        .core_hash_i      (core_hash_i),
        .core_out_valid_i (core_out_valid_i),
        .core_out_ready_o (core_out_ready_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one cycle and sample just after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [511:0] v, input int w);
        logic [511:0] t;
        t = v << (32 * w);
        return t[511:480];
    endfunction

    function automatic logic ops_ok(input logic [31:0] it, input logic [5:0] sl,
                                    input logic [511:0] p, input logic [511:0] s);
        return (core_iters_o === it) && (core_salt_len_o === sl) &&
               (core_pass_o === p) && (core_salt_o === s) && (cmd_ready_o === 1'b0);
    endfunction

    task automatic send_word(input logic [31:0] d);
        int budget;
        budget = 0;
        cmd_valid_i = 1'b1;
        cmd_data_i  = d;
        while (!cmd_ready_o && budget < 300) begin
            step();
            budget++;
        end
        if (budget >= 300) check("cmd_accept_timeout", 1'b0, 1'b1);
        step();
        cmd_valid_i = 1'b0;
    endtask

    // Sends words 0..last of a job; gaps randomly drop cmd_valid_i.
    task automatic send_job(input logic [31:0] it, input logic [31:0] slw,
                            input logic [511:0] p, input logic [511:0] s,
                            input bit gaps, input int last);
        logic [31:0] d;
        for (int w = 0; w <= last; w++) begin
            if (w == 0)       d = it;
            else if (w == 1)  d = slw;
            else if (w < 18)  d = word_of(p, w - 2);
            else              d = word_of(s, w - 18);
            if (gaps) begin
                cmd_valid_i = 1'b0;
                cmd_data_i  = $urandom;
                repeat ($urandom_range(0, 2)) step();
            end
            send_word(d);
        end
        if (last == 33) check("issue_next_cycle", core_in_valid_o, 1'b1);
    endtask

    // Core model: accepts after in_dly extra ISSUE cycles, returns after
    // out_dly extra WAIT cycles, and pushes the expected result words.
    task automatic run_core(input logic [31:0] it, input logic [5:0] sl,
                            input logic [511:0] p, input logic [511:0] s,
                            input int in_dly, input int out_dly, input logic [255:0] h);
        int          budget;
        logic        ok;
        logic [255:0] t;
        budget = 0;
        while (!core_in_valid_o && budget < 50) begin
            step();
            budget++;
        end
        check("issue_valid", core_in_valid_o, 1'b1);
        check("core_iters", core_iters_o, it);
        check("core_salt_len", core_salt_len_o, sl);
        check("core_pass", core_pass_o, p);
        check("core_salt", core_salt_o, s);
        ok = 1'b1;
        for (int c = 0; c < in_dly; c++) begin
            core_out_valid_i = 1'b1;
            core_hash_i      = ~h;
            ok &= ops_ok(it, sl, p, s) && core_in_valid_o && busy_o && !core_out_ready_o;
            step();
        end
        core_out_valid_i = 1'b0;
        core_in_ready_i  = 1'b1;
        step();
        core_in_ready_i  = 1'b0;
        check("in_valid_fall", core_in_valid_o, 1'b0);
        check("out_ready_wait", core_out_ready_o, 1'b1);
        for (int c = 0; c < out_dly; c++) begin
            ok &= ops_ok(it, sl, p, s) && core_out_ready_o && busy_o && !res_valid_o;
            step();
        end
        core_out_valid_i = 1'b1;
        core_hash_i      = h;
        for (int k = 0; k < 8; k++) begin
            t = h << (32 * k);
            exp_q.push_back(t[255:224]);
        end
`ifdef PBKDF2_HOST_CYCLE_COUNT_EN
        exp_q.push_back(32'(in_dly + out_dly + 2));
`endif
        step();
        core_out_valid_i = 1'b0;
        core_hash_i      = '0;
        check("operands_stable", ok, 1'b1);
        check("res_valid_after_capture", res_valid_o, 1'b1);
        check("out_ready_drop", core_out_ready_o, 1'b0);
    endtask

    // Drains the result stream against the scoreboard; optional 5-cycle stall.
    task automatic collect(input int stall_idx);
        int          got;
        int          budget;
        logic        ok;
        logic [31:0] hold;
        logic [31:0] e;
        got = 0;
        budget = 0;
        res_ready_i = 1'b1;
        while (got < NUM_RES && budget < 200) begin
            if (got == stall_idx && res_valid_o) begin
                res_ready_i = 1'b0;
                hold = res_data_o;
                ok = 1'b1;
                repeat (5) begin
                    step();
                    ok &= res_valid_o && (res_data_o === hold);
                end
                check("stall_hold", ok, 1'b1);
                res_ready_i = 1'b1;
            end
            if (res_valid_o) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                check($sformatf("res_word%0d", got), res_data_o, e);
                got++;
            end
            step();
            budget++;
        end
        check("res_word_count", got, NUM_RES);
        check("res_valid_done", res_valid_o, 1'b0);
        check("cmd_ready_after_send", cmd_ready_o, 1'b1);
        check("busy_idle", busy_o, 1'b0);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready_o, 1'b1);
        check({tag, "_zero_outs"},
              {res_valid_o, core_in_valid_o, core_out_ready_o, busy_o, res_data_o,
               core_iters_o, core_salt_len_o}, '0);
        check({tag, "_pass"}, core_pass_o, '0);
        check({tag, "_salt"}, core_salt_o, '0);
    endtask

    logic [511:0] pa, sa, pb, sb;
    logic [255:0] ramp;

    initial begin
        rst_ni = 1'b0;
        cmd_data_i = '0;
        cmd_valid_i = 1'b0;
        res_ready_i = 1'b0;
        core_in_ready_i = 1'b0;
        core_hash_i = '0;
        core_out_valid_i = 1'b0;
        for (int b = 0; b < 32; b++) ramp[255 - 8*b -: 8] = 8'(b);
        for (int w = 0; w < 16; w++) begin
            pa[511 - 32*w -: 32] = 32'hA000_0000 + 32'(w);
            sa[511 - 32*w -: 32] = 32'h5000_0000 + 32'(w);
            pb[511 - 32*w -: 32] = 32'hC0DE_0000 + 32'(w * 7);
            sb[511 - 32*w -: 32] = 32'h0BAD_0000 + 32'(w * 3);
        end
        repeat (3) step();
        check_reset_outputs("rst_held");
        rst_ni = 1'b1;
        step();
        check_reset_outputs("rst_released");

        // Single job, minimum iterations, ramp hash.
        send_job(32'd1, 32'd4, pa, sa, 1'b0, 33);
        run_core(32'd1, 6'd4, pa, sa, 0, 0, ramp);
        collect(-1);

        // iters = 0 stored as 1; upper salt_len bits ignored.
        send_job(32'd0, 32'hFFFF_FFC5, pb, sb, 1'b0, 33);
        run_core(32'd1, 6'd5, pb, sb, 1, 9, ~ramp);
        collect(-1);

        // Backpressure: random command gaps, stall on result word 3.
        send_job(32'd4096, 32'd63, sa, pb, 1'b1, 33);
        run_core(32'd4096, 6'd63, sa, pb, 0, 2, {ramp[127:0], ramp[255:128]});
        collect(3);

        // Core latency: late accept, long return.
        send_job(32'hFFFF_FFFF, 32'd16, pb, pa, 1'b0, 33);
        run_core(32'hFFFF_FFFF, 6'd16, pb, pa, 3, 100, 256'h1234_5678 ^ ramp);
        collect(-1);

        // Reset after word 20 of a job, then a complete fresh job.
        send_job(32'd77, 32'd9, sb, sa, 1'b0, 20);
        check("busy_mid_load", busy_o, 1'b1);
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("rst_mid_job");
        step();
        rst_ni = 1'b1;
        step();
        send_job(32'd2, 32'd1, pa, pb, 1'b0, 33);
        run_core(32'd2, 6'd1, pa, pb, 0, 0, ramp ^ {8{32'h0F0F_0F0F}});
        collect(-1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
